// File: rtl/key_decoder.sv
// key_decoder: PS/2 scan-code set 2 byte stream to four held-key levels.
// Tracks make/break/extended prefixes, drops a stale prefix after TIMEOUT
// idle cycles, and clears every key on keyboard error or self-test bytes.
module key_decoder #(
    parameter logic [7:0]  SC0     = 8'h1C,
    parameter logic [7:0]  SC1     = 8'h1B,
    parameter logic [7:0]  SC2     = 8'h23,
    parameter logic [7:0]  SC3     = 8'h2B,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       code_valid,
    input  logic [7:0] code,
    output logic       key0,
    output logic       key1,
    output logic       key2,
    output logic       key3,
    output logic       any_key,
    output logic       prefix_timeout
);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_ERR0  = 8'h00;
    localparam logic [7:0] CODE_ERR1  = 8'hFF;
    localparam logic [7:0] CODE_BAT0  = 8'hAA;
    localparam logic [7:0] CODE_BAT1  = 8'hFC;

    typedef enum logic [1:0] {
        IDLE,
        BREAK,
        EXT,
        EXT_BREAK
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  keys, keys_nx;
    logic [15:0] cnt, cnt_nx;
    logic        timeout_nx;
    logic [3:0]  hit;

    // Which keys the current byte names; colliding SCn values all match.
    assign hit = {code == SC3, code == SC2, code == SC1, code == SC0};

    // Next-state, next-key and prefix timer decisions for this cycle.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_nx   = state;
        keys_nx    = keys;
        cnt_nx     = cnt;
        timeout_nx = 1'b0;
        if (code_valid) begin
            cnt_nx = 16'd0;
            if (code == CODE_ERR0 || code == CODE_ERR1) begin
                keys_nx  = 4'b0000;
                state_nx = IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (code == CODE_EXT)
                            state_nx = EXT;
                        else if (code == CODE_BREAK)
                            state_nx = BREAK;
                        else if (code == CODE_BAT0 || code == CODE_BAT1)
                            keys_nx = 4'b0000;
                        else
                            keys_nx = keys | hit;
                    end
                    BREAK: begin
                        if (code == CODE_BREAK)
                            state_nx = BREAK;
                        else if (code == CODE_EXT)
                            state_nx = EXT;
                        else begin
                            keys_nx  = keys & ~hit;
                            state_nx = IDLE;
                        end
                    end
                    EXT: begin
                        if (code == CODE_BREAK)
                            state_nx = EXT_BREAK;
                        else if (code == CODE_EXT)
                            state_nx = EXT;
                        else
                            state_nx = IDLE;
                    end
                    EXT_BREAK: begin
                        if (code == CODE_EXT)
                            state_nx = EXT;
                        else if (code == CODE_BREAK)
                            state_nx = EXT_BREAK;
                        else
                            state_nx = IDLE;
                    end
                    default: state_nx = IDLE;
                endcase
            end
        end else if (state == IDLE) begin
            cnt_nx = 16'd0;
        end else if (cnt == TIMEOUT) begin
            // Abandon the prefix; the counter is reset here so it never wraps.
            state_nx   = IDLE;
            cnt_nx     = 16'd0;
            timeout_nx = 1'b1;
        end else begin
            cnt_nx = cnt + 16'd1;
        end
    end

    // State, key levels, timer and registered flags; reset wins over any byte.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
        if (RESET) begin
            state          <= IDLE;
            keys           <= 4'b0000;
            cnt            <= 16'd0;
            any_key        <= 1'b0;
            prefix_timeout <= 1'b0;
        end else begin
            state          <= state_nx;
            keys           <= keys_nx;
            cnt            <= cnt_nx;
            any_key        <= |keys_nx;
            prefix_timeout <= timeout_nx;
        end
    end

    assign key0 = keys[0];
    assign key1 = keys[1];
    assign key2 = keys[2];
    assign key3 = keys[3];

endmodule

// File: tb/tb_key_decoder.sv
// tb_key_decoder: directed byte vectors with hand-written expected outputs.
// Expected vector layout is {prefix_timeout, any_key, key3, key2, key1, key0}.
module tb_key_decoder;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       code_valid = 1'b0;
    logic [7:0] code = 8'h00;
    logic       key0, key1, key2, key3, any_key, prefix_timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         due_q[$];
    logic [5:0] exp_q[$];
    string      name_q[$];

    key_decoder #(.TIMEOUT(16'd4)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .code_valid    (code_valid),
        .code          (code),
        .key0          (key0),
        .key1          (key1),
        .key2          (key2),
        .key3          (key3),
        .any_key       (any_key),
        .prefix_timeout(prefix_timeout)
    );

    always #5 CLK = ~CLK;

    // Cycle index used to schedule when each expectation falls due.
    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: pops expectations that fall due and compares away from the edge.
    always @(negedge CLK) begin
        logic [5:0] act;
        act = {prefix_timeout, any_key, key3, key2, key1, key0};
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            total++;
            if (due_q[0] < cyc) begin
                bad++;
                $display("FAIL %s: expectation missed at cycle %0d (due %0d)", name_q[0], cyc, due_q[0]);
            end else if (act !== exp_q[0]) begin
                bad++;
                $display("FAIL %s: got %b expected %b (cycle %0d)", name_q[0], act, exp_q[0], cyc);
            end
            void'(due_q.pop_front());
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after that edge.
    task automatic step(input logic rst, input logic v, input logic [7:0] b,
                        input logic [5:0] exp, input string name);
        @(posedge CLK);
        #1;
        RESET      = rst;
        code_valid = v;
        code       = b;
        due_q.push_back(cyc + 1);
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    task automatic send(input logic [7:0] b, input logic [5:0] exp, input string name);
        step(1'b0, 1'b1, b, exp, name);
    endtask

    task automatic idle(input int n, input logic [5:0] exp, input string name);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, exp, name);
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, 8'h00, 6'b000000, "reset");
        step(1'b1, 1'b1, 8'h1C, 6'b000000, "reset_beats_byte");

        // Basic make/break, back-to-back strobes
        send(8'h1C, 6'b010001, "make_1C");
        send(8'h1B, 6'b010011, "make_1B");
        send(8'hF0, 6'b010011, "break_prefix");
        send(8'h1C, 6'b010010, "break_1C");
        send(8'hF0, 6'b010010, "break_prefix2");
        send(8'h1B, 6'b000000, "break_1B");

        // Typematic repeat and stray break
        send(8'h23, 6'b010100, "typematic_1");
        send(8'h23, 6'b010100, "typematic_2");
        send(8'h23, 6'b010100, "typematic_3");
        send(8'hF0, 6'b010100, "stray_prefix");
        send(8'h2B, 6'b010100, "stray_break_2B");
        send(8'h1C, 6'b010101, "idle_after_stray");
        send(8'hF0, 6'b010101, "clr_prefix_a");
        send(8'h1C, 6'b010100, "clr_1C");
        send(8'hF0, 6'b010100, "clr_prefix_b");
        send(8'h23, 6'b000000, "clr_23");

        // Extended codes never touch keys
        send(8'hE0, 6'b000000, "ext_prefix");
        send(8'h1C, 6'b000000, "ext_make_1C");
        send(8'hE0, 6'b000000, "extbrk_e0");
        send(8'hF0, 6'b000000, "extbrk_f0");
        send(8'h1C, 6'b000000, "ext_break_1C");
        send(8'h1C, 6'b010001, "make_after_ext");
        send(8'hE0, 6'b010001, "hold_e0");
        send(8'hF0, 6'b010001, "hold_f0");
        send(8'h1C, 6'b010001, "ext_break_keeps");
        send(8'h1B, 6'b010011, "idle_after_extbrk");
        send(8'hF0, 6'b010011, "clr_prefix_c");
        send(8'h1C, 6'b010010, "clr_1C_b");
        send(8'hF0, 6'b010010, "clr_prefix_d");
        send(8'h1B, 6'b000000, "clr_1B_b");

        // Timeout: F0 then five idle cycles, pulse appears after the fifth
        send(8'hF0, 6'b000000, "to_prefix");
        idle(4, 6'b000000, "to_waiting");
        idle(1, 6'b100000, "to_pulse");
        send(8'h1C, 6'b010001, "to_then_make");
        idle(1, 6'b010001, "to_no_second_pulse");

        // Byte arriving exactly at the timeout cycle wins
        send(8'hF0, 6'b010001, "race_prefix");
        idle(4, 6'b010001, "race_waiting");
        send(8'h1C, 6'b000000, "race_byte_wins");
        idle(2, 6'b000000, "race_no_pulse");

        // Repeated F0 restarts the timer
        send(8'hF0, 6'b000000, "restart_prefix");
        idle(3, 6'b000000, "restart_wait_a");
        send(8'hF0, 6'b000000, "restart_f0");
        idle(4, 6'b000000, "restart_wait_b");
        idle(1, 6'b100000, "restart_pulse");
        idle(1, 6'b000000, "restart_pulse_end");

        // Keyboard error while in Break
        send(8'h1C, 6'b010001, "hold_a0");
        send(8'h1B, 6'b010011, "hold_a1");
        send(8'h23, 6'b010111, "hold_a2");
        send(8'h2B, 6'b011111, "hold_a3");
        send(8'hF0, 6'b011111, "err_prefix");
        send(8'hFF, 6'b000000, "err_ff_clears");
        send(8'h1C, 6'b010001, "err_then_make");

        // Self-test result in Idle
        send(8'h1B, 6'b010011, "hold_b1");
        send(8'h23, 6'b010111, "hold_b2");
        send(8'h2B, 6'b011111, "hold_b3");
        send(8'hAA, 6'b000000, "bat_aa_clears");

        // Error byte 00 from Ext
        send(8'h2B, 6'b011000, "hold_c3");
        send(8'hE0, 6'b011000, "err_ext_prefix");
        send(8'h00, 6'b000000, "err_00_clears");
        send(8'hF0, 6'b000000, "err_idle_check");
        send(8'h2B, 6'b000000, "err_idle_break");

        // Reset mid-sequence drops the prefix
        send(8'h1B, 6'b010010, "rst_hold_1B");
        send(8'hF0, 6'b010010, "rst_prefix");
        step(1'b1, 1'b1, 8'h1B, 6'b000000, "rst_mid_clears");
        send(8'h1B, 6'b010010, "rst_then_make");
        idle(1, 6'b010010, "rst_hold_stable");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && due_q.size() > 0; i++) @(posedge CLK);
        @(posedge CLK);
        if (due_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", due_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_decoder.md
# key_decoder

Upstream front end for the arpeggiator/voice path. It turns a stream of PS/2 scan-code set 2 bytes into four held-key levels, `key0`–`key3`. Each level rises on a make code and falls on the matching break sequence. The outputs drive the arpeggiator key inputs directly. Byte framing from the PS/2 line is done upstream; this block sees only validated bytes with a one-cycle strobe.

## Interface
Parameters:
- `SC0`, default 8'h1C (A): scan code mapped to `key0`.
- `SC1`, default 8'h1B (S): scan code mapped to `key1`.
- `SC2`, default 8'h23 (D): scan code mapped to `key2`.
- `SC3`, default 8'h2B (F): scan code mapped to `key3`.
- `TIMEOUT`, default 16'd50000: idle cycles allowed in a prefix state before the prefix is dropped.

Ports:
- `CLK` — in, 1: system clock. Single clock domain.
- `RESET` — in, 1: synchronous, active-high reset.
- `code_valid` — in, 1: one-cycle strobe; `code` is valid in this cycle.
- `code` — in, 8: received scan-code byte.
- `key0`, `key1`, `key2`, `key3` — out, 1 each: held level of the key mapped by `SC0`–`SC3`.
- `any_key` — out, 1: OR of `key0`–`key3`, registered.
- `prefix_timeout` — out, 1: one-cycle pulse when a pending prefix is abandoned.

## Operation
- States: `Idle`, `Break` (after F0), `Ext` (after E0), `ExtBreak` (after E0 F0).
- A byte is acted on only in a cycle with `code_valid`=1. Bytes are processed in the current state.
- In any state, a byte of 8'h00 or 8'hFF (keyboard error):
  - clears all keys;
  - moves to `Idle`.
- From `Idle`:
  - E0 → `Ext`.
  - F0 → `Break`.
  - AA or FC (self-test result) → clear all keys; stay `Idle`.
  - A byte equal to `SCn` → set `keyn`=1.
  - Any other byte → ignored.
- From `Break`:
  - F0 → stay `Break`; timer restarts.
  - E0 → `Ext`.
  - A byte equal to `SCn` → clear `keyn`; go `Idle`.
  - Any other byte → go `Idle`; no key change.
- From `Ext`:
  - F0 → `ExtBreak`.
  - E0 → stay `Ext`; timer restarts.
  - Any other byte → go `Idle`. Extended make codes never touch keys.
- From `ExtBreak`:
  - E0 → `Ext`.
  - F0 → stay `ExtBreak`; timer restarts.
  - Any other byte → go `Idle`; no key change.
- Key-level rules:
  - A make code for an already-held key (typematic repeat) leaves it at 1.
  - A break for a key not held has no effect.
  - Keys are independent; any combination may be held.
  - If `SCn` values collide, every matching key is affected.
- Timeout counter (16 bit):
  - Forced to 0 in `Idle` and on every accepted byte.
  - In a prefix state, increments by 1 each cycle that `code_valid`=0.
  - When the counter equals `TIMEOUT` in a cycle with `code_valid`=0, the next edge moves the state to `Idle` and zeroes the counter. `prefix_timeout` pulses high for exactly that one following cycle.
  - Keys are unchanged by a timeout.
  - The counter never wraps; the timeout fires first.

## Timing
- Reset: at the first edge with `RESET`=1, all outputs go to 0, the state goes to `Idle`, and the counter goes to 0. Reset overrides any byte in the same cycle. Reset mid-sequence discards the pending prefix.
- Latency: a byte strobed in cycle N updates `keyN`, `any_key` and the state at the edge ending cycle N. The outputs are visible in cycle N+1.
- `any_key` is registered from the next-state key values, so it updates in the same cycle as the keys.
- Back-to-back strobes, one byte per cycle, are fully supported.
- A timeout and `code_valid` in the same cycle cannot both fire: the byte wins and the timeout does not fire.
- With `TIMEOUT`=T, a prefix byte accepted at edge E is dropped at edge E+T+1 if no byte arrives in between.

## Test plan
- Reset, then bytes 1C, 1B back-to-back → `key0`=1 in the cycle after the first strobe, `key1`=1 one cycle later, `any_key`=1. Then F0, 1C → `key0`=0 and `key1`=1 in the cycle after the 1C strobe.
- Typematic and stray breaks: 23, 23, 23, then F0 2B → `key2` stays 1 throughout; `key3` stays 0; state ends in `Idle`.
- Extended codes: E0 1C, then E0 F0 1C → `key0` never changes. Sequence 1C, E0 F0 1C → `key0` stays 1.
- Timeout with `TIMEOUT`=4: F0, then 5 idle cycles → `prefix_timeout` pulses once. A following 1C sets `key0`=1 (it is treated as a make, not a break).
- Error/BAT: hold all four keys, then send FF while in `Break` → all keys 0 and state `Idle`. Repeat the hold, send AA in `Idle` → all keys 0.
- Reset mid-sequence: hold `key1`, send F0, assert `RESET` one cycle, then 1B → `key1` is 0 after reset and 1 after the 1B strobe.
